// File: rtl/uart_tx_responder.sv
// UART 8N1 transmitter behind a write-only bus responder: byte writes to ADDR_TX are queued
// in a small FIFO and serialised; every accepted write gets an OK/ERROR response.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte on its last cycle
module uart_tx_responder #(
   parameter int                   BUS_WIDTH    = 32,
   parameter int                   RESP_WIDTH   = 2,
   parameter logic [BUS_WIDTH-1:0] ADDR_TX      = 'h8004,
   parameter int                   FIFO_DEPTH   = 4,
   parameter int                   CLKS_PER_BIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dw_data_addr_valid,
   output logic                          dw_data_addr_ready,
   input  logic [BUS_WIDTH-1:0]          dw_addr,
   input  logic [BUS_WIDTH-1:0]          dw_data,
   input  logic [BUS_WIDTH/8-1:0]        dw_strobe,
   output logic                          dw_resp_valid,
   input  logic                          dw_resp_ready,
   output logic [RESP_WIDTH-1:0]         dw_resp,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [RESP_WIDTH-1:0] RESP_OK  = '0;
   localparam logic [RESP_WIDTH-1:0] RESP_ERR = RESP_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [AW:0]     wr_ptr_q, rd_ptr_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic            resp_valid_q;
   logic [RESP_WIDTH-1:0] resp_q;
   logic            hs, push, pop, fifo_empty, fifo_full, baud_last;
   logic            unused_bits;

   assign unused_bits = ^{dw_data[BUS_WIDTH-1:8], dw_strobe[BUS_WIDTH/8-1:1]};

   // Pointers carry an extra wrap bit so equal indices can mean either empty or full.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_level = wr_ptr_q - rd_ptr_q;

   assign dw_data_addr_ready = !resp_valid_q && !fifo_full;
   assign hs        = dw_data_addr_valid && dw_data_addr_ready;
   assign push      = hs && (dw_addr == ADDR_TX) && dw_strobe[0];
   assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));

   assign dw_resp_valid = resp_valid_q;
   assign dw_resp       = resp_q;
   assign tx_busy       = (state_q != S_IDLE) || (fifo_level != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_q       <= RESP_OK;
      end else if (hs) begin
         resp_valid_q <= 1'b1;
         resp_q       <= push ? RESP_OK : RESP_ERR;
      end else if (dw_resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= dw_data[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      uart_tx = 1'b1;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q[AW-1:0]];
               state_d = S_START;
            end
         end
         S_START: begin
            uart_tx = 1'b0;
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            uart_tx = shift_q[0];
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_STOP: begin
            // Popping here keeps queued frames back to back with no idle gap.
            if (baud_last) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q[AW-1:0]];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder: directed writes, response scoreboard and a line decoder
// that checks each frame's byte and start cycle against queued expectations.
module tb_uart_tx_responder;
   localparam int CPB = 4;

   typedef struct {
      logic [7:0] b;
      int         mode;   // 0 any start, 1 start at given cycle, 2 directly after previous frame
      int         start;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dw_data_addr_valid = 1'b0;
   logic        dw_data_addr_ready;
   logic [31:0] dw_addr = '0;
   logic [31:0] dw_data = '0;
   logic [3:0]  dw_strobe = '0;
   logic        dw_resp_valid;
   logic        dw_resp_ready = 1'b1;
   logic [1:0]  dw_resp;
   logic        uart_tx;
   logic        tx_busy;
   logic [2:0]  fifo_level;

   uart_tx_responder #(
      .BUS_WIDTH(32), .RESP_WIDTH(2), .ADDR_TX(32'h8004),
      .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk), .rst(rst),
      .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
      .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
      .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp),
      .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [1:0] exp_resp_q[$];
   frame_t     exp_frames[$];
   bit         saw_full = 0;

   // Response scoreboard
   always @(negedge clk) begin
      if (!rst && dw_resp_valid && dw_resp_ready) begin
         if (exp_resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: got code %0d expected no response", dw_resp);
         end else begin
            chk("resp_code", 32'(dw_resp), 32'(exp_resp_q.pop_front()));
         end
      end
   end

   // Line decoder
   bit         in_frame = 0;
   int         s_cyc, off;
   int         prev_start = -1000;
   logic [7:0] rx;
   frame_t     cur;
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0;
      end else if (!in_frame) begin
         if (uart_tx === 1'b0) begin
            in_frame = 1; s_cyc = cyc; rx = '0;
         end
      end else begin
         off = cyc - s_cyc;
         if (off == CPB/2) chk("start_bit_low", 32'(uart_tx), 0);
         if (off >= CPB && off < 9*CPB && (off % CPB) == CPB/2) rx[off/CPB - 1] = uart_tx;
         if (off == 9*CPB + CPB/2) begin
            chk("stop_bit_high", 32'(uart_tx), 1);
            if (exp_frames.size() == 0) begin
               checks++; errors++;
               $display("FAIL frame_unexpected: got byte 0x%0h expected no frame", rx);
            end else begin
               cur = exp_frames.pop_front();
               chk("frame_byte", 32'(rx), 32'(cur.b));
               if (cur.mode == 1) chk("frame_start_cycle", s_cyc, cur.start);
               if (cur.mode == 2) chk("frame_contiguous", s_cyc, prev_start + 10*CPB);
            end
            prev_start = s_cyc;
            in_frame = 0;
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] er, input bit push_b, input int mode, output int hs);
      int  n = 0;
      bit  done = 0;
      dw_addr = a; dw_data = d; dw_strobe = s; dw_data_addr_valid = 1'b1;
      hs = -1;
      while (!done && n < 300) begin
         @(negedge clk);
         if (fifo_level == 3'd4) begin
            saw_full = 1;
            chk("ready_low_when_full", 32'(dw_data_addr_ready), 0);
         end
         if (dw_data_addr_ready) begin
            hs = cyc; done = 1;
            exp_resp_q.push_back(er);
            if (push_b) exp_frames.push_back('{d[7:0], mode, cyc + 2});
         end
         @(posedge clk); #1;
         n++;
      end
      dw_data_addr_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL write_timeout: got no handshake expected one within 300 cycles");
      end else begin
         @(negedge clk);
         chk("resp_valid_after_hs", 32'(dw_resp_valid), 1);
         chk("ready_low_after_hs", 32'(dw_data_addr_ready), 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (!tx_busy) ok = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout: got tx_busy 1 expected 0 within 500 cycles");
      end
      chk("line_high_when_idle", 32'(uart_tx), 1);
      @(posedge clk); #1;
   endtask

   int hs, hs2, m;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset and idle
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_uart_tx", 32'(uart_tx), 1);
      chk("rst_tx_busy", 32'(tx_busy), 0);
      chk("rst_resp_valid", 32'(dw_resp_valid), 0);
      chk("rst_resp", 32'(dw_resp), 0);
      chk("rst_ready", 32'(dw_data_addr_ready), 1);
      chk("rst_level", 32'(fifo_level), 0);
      @(posedge clk); #1;

      // Single byte 0x41
      dw_resp_ready = 1'b1;
      wr(32'h8004, 32'h41, 4'hF, 2'd0, 1, 1, hs);
      wait_idle();

      // Error responses
      wr(32'h8008, 32'h77, 4'hF, 2'd1, 0, 0, hs);
      @(negedge clk);
      chk("err_addr_level", 32'(fifo_level), 0);
      chk("err_addr_line", 32'(uart_tx), 1);
      @(posedge clk); #1;
      wr(32'h8004, 32'h77, 4'hE, 2'd1, 0, 0, hs);
      @(negedge clk);
      chk("err_strobe_level", 32'(fifo_level), 0);
      chk("err_strobe_line", 32'(uart_tx), 1);
      chk("err_strobe_busy", 32'(tx_busy), 0);
      @(posedge clk); #1;

      // Six bytes through a four-deep FIFO
      saw_full = 0;
      for (int i = 0; i < 6; i++)
         wr(32'h8004, 32'h30 + i, 4'hF, 2'd0, 1, (i == 0) ? 1 : 2, hs);
      chk("fifo_reached_full", 32'(saw_full), 1);
      wait_idle();
      chk("burst_frames_drained", exp_frames.size(), 0);

      // Response back-pressure
      dw_resp_ready = 1'b0;
      wr(32'h8004, 32'h55, 4'hF, 2'd0, 1, 1, hs);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("held_resp_valid", 32'(dw_resp_valid), 1);
         chk("held_resp", 32'(dw_resp), 0);
         chk("held_ready_low", 32'(dw_data_addr_ready), 0);
         @(posedge clk); #1;
      end
      m = cyc;
      dw_resp_ready = 1'b1;
      wr(32'h8004, 32'h66, 4'hF, 2'd0, 1, 2, hs2);
      chk("next_hs_after_release", hs2, m + 1);
      wait_idle();

      // Reset in the middle of a frame with two bytes queued
      wr(32'h8004, 32'hA1, 4'hF, 2'd0, 1, 1, hs);
      wr(32'h8004, 32'hA2, 4'hF, 2'd0, 1, 2, hs2);
      wr(32'h8004, 32'hA3, 4'hF, 2'd0, 1, 2, hs2);
      while (cyc < hs + 12) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("midframe_level", 32'(fifo_level), 2);
      chk("midframe_busy", 32'(tx_busy), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("async_rst_line", 32'(uart_tx), 1);
      chk("async_rst_level", 32'(fifo_level), 0);
      chk("async_rst_resp_valid", 32'(dw_resp_valid), 0);
      exp_frames.delete();
      exp_resp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      wr(32'h8004, 32'h5A, 4'hF, 2'd0, 1, 1, hs);
      wait_idle();

      chk("all_frames_seen", exp_frames.size(), 0);
      chk("all_resps_seen", exp_resp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
